// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply-divide unit.
// Used by the top level and the iterative divider core.
package hilo_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  // Bit positions within the decoder's one-hot muldiv_op field.
  localparam int unsigned OpMult  = 7;
  localparam int unsigned OpMultu = 6;
  localparam int unsigned OpDiv   = 5;
  localparam int unsigned OpDivu  = 4;
  localparam int unsigned OpMfhi  = 3;
  localparam int unsigned OpMflo  = 2;
  localparam int unsigned OpMthi  = 1;
  localparam int unsigned OpMtlo  = 0;

  localparam int unsigned DIV_ITER = 32;

endpackage

// File: rtl/hilo_muldiv_if.sv
// EXE-stage request/response bundle between the pipeline and the HI/LO unit.
// The pipeline side is the master; the unit is the slave.
interface hilo_muldiv_if;
  logic        valid;
  logic [7:0]  muldiv_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic [31:0] result;

  modport master (
    output valid, muldiv_op, src_a, src_b, flush,
    input  stall, result
  );

  modport slave (
    input  valid, muldiv_op, src_a, src_b, flush,
    output stall, result
  );
endinterface

// File: rtl/div_iter.sv
// Unsigned restoring radix-2 divider: one quotient bit per enabled cycle, DIV_ITER steps.
// done_o is high during the cycle whose clock edge performs the final step.
module div_iter
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;

  logic [32:0] partial;
  logic        fits;

  // Dividend bits shift out of quo_q into the partial remainder as quotient bits shift in.
  assign partial = {rem_q, quo_q[31]};
  assign fits    = partial >= {1'b0, dsr_q};

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = 5'(DIV_ITER - 1);
      quo_d  = dividend_i;
      rem_d  = '0;
      dsr_d  = divisor_i;
    end else if (busy_q && step_i) begin
      quo_d = {quo_q[30:0], fits};
      // The difference is below the divisor, so its low 32 bits are exact.
      rem_d = fits ? (partial[31:0] - dsr_q) : partial[31:0];
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign done_o      = busy_q && (cnt_q == '0);

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: 2-cycle multiply, 33-cycle iterative divide, MFHI/MFLO/MTHI/MTLO.
// Holds the pipeline via stall until the result is ready; flush aborts without touching HI/LO.
module hilo_muldiv
  import hilo_pkg::*;
(
  input logic            clk,
  input logic            rst,
  hilo_muldiv_if.slave   bus
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        mul_signed_q, mul_signed_d;
  logic [63:0] prod_q, prod_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        is_div_q, is_div_d;

  logic [7:0]  op;
  logic        one_hot;
  logic        act;
  logic        op_mul;
  logic        op_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic        div_start;
  logic        div_done;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        stall;

  assign op      = bus.muldiv_op;
  assign one_hot = (op != '0) && ((op & (op - 8'd1)) == '0);
  // rst is folded in so stall and result read zero while reset is held.
  assign act     = bus.valid && !bus.flush && !rst && one_hot;
  assign op_mul  = op[OpMult] || op[OpMultu];
  assign op_div  = op[OpDiv] || op[OpDivu];

  assign a_mag = (op[OpDiv] && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign b_mag = (op[OpDiv] && bus.src_b[31]) ? -bus.src_b : bus.src_b;

  assign ext_a = mul_signed_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
  assign ext_b = mul_signed_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};

  div_iter u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .step_i      (act),
    .abort_i     (bus.flush),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    a_d          = a_q;
    b_d          = b_q;
    mul_signed_d = mul_signed_q;
    prod_d       = prod_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    is_div_d     = is_div_q;
    div_start    = 1'b0;
    stall        = 1'b0;
    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (act) begin
            if (op_mul) begin
              a_d          = bus.src_a;
              b_d          = bus.src_b;
              mul_signed_d = op[OpMult];
              is_div_d     = 1'b0;
              state_d      = StMul;
              stall        = 1'b1;
            end else if (op_div) begin
              div_start = 1'b1;
              q_neg_d   = op[OpDiv] && (bus.src_a[31] ^ bus.src_b[31]);
              r_neg_d   = op[OpDiv] && bus.src_a[31];
              is_div_d  = 1'b1;
              state_d   = StDiv;
              stall     = 1'b1;
            end else if (op[OpMthi]) begin
              hi_d = bus.src_a;
            end else if (op[OpMtlo]) begin
              lo_d = bus.src_a;
            end
          end
        end
        StMul: begin
          stall = 1'b1;
          if (act) begin
            prod_d  = ext_a * ext_b;
            state_d = StDone;
          end
        end
        StDiv: begin
          stall = 1'b1;
          if (act && div_done) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (act) begin
            if (is_div_q) begin
              lo_d = q_neg_q ? -div_quo : div_quo;
              hi_d = r_neg_q ? -div_rem : div_rem;
            end else begin
              hi_d = prod_q[63:32];
              lo_d = prod_q[31:0];
            end
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      hi_q         <= '0;
      lo_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      prod_q       <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      is_div_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mul_signed_q <= mul_signed_d;
      prod_q       <= prod_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      is_div_q     <= is_div_d;
    end
  end

  assign bus.stall  = stall;
  assign bus.result = (act && op[OpMfhi]) ? hi_q :
                      (act && op[OpMflo]) ? lo_q : '0;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: reference model of HI/LO feeds a scoreboard queue
// that is drained when MFHI/MFLO results appear; stall lengths are checked per op.
module tb_hilo_muldiv;

  localparam logic [7:0] OP_MULT  = 8'h80;
  localparam logic [7:0] OP_MULTU = 8'h40;
  localparam logic [7:0] OP_DIV   = 8'h20;
  localparam logic [7:0] OP_DIVU  = 8'h10;
  localparam logic [7:0] OP_MFHI  = 8'h08;
  localparam logic [7:0] OP_MFLO  = 8'h04;
  localparam logic [7:0] OP_MTHI  = 8'h02;
  localparam logic [7:0] OP_MTLO  = 8'h01;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  logic [31:0] model_hi;
  logic [31:0] model_lo;
  logic [31:0] exp_q[$];

  hilo_muldiv_if bus ();

  hilo_muldiv u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_exec(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    logic   [63:0]   up;
    int              sa;
    int              sb;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {model_hi, model_lo} = sp;
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {model_hi, model_lo} = up;
      end
      OP_DIVU: begin
        if (b == 0) begin
          model_lo = 32'hFFFF_FFFF;
          model_hi = a;
        end else begin
          model_lo = a / b;
          model_hi = a % b;
        end
      end
      OP_DIV: begin
        if (b == 0) begin
          model_hi = a;
          model_lo = a[31] ? 32'h1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          model_lo = 32'h8000_0000;
          model_hi = 32'h0;
        end else begin
          sa = $signed(a);
          sb = $signed(b);
          model_lo = sa / sb;
          model_hi = sa % sb;
        end
      end
      OP_MTHI: model_hi = a;
      OP_MTLO: model_lo = a;
      default: ;
    endcase
  endtask

  // Present one op from just after a rising edge until the pipeline is released.
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int ns, output logic [31:0] res);
    bit done_f;
    done_f        = 1'b0;
    ns            = 0;
    res           = '0;
    bus.valid     = 1'b1;
    bus.muldiv_op = op;
    bus.src_a     = a;
    bus.src_b     = b;
    for (int i = 0; i < 100 && !done_f; i++) begin
      @(negedge clk);
      if (!bus.stall) begin
        res    = bus.result;
        done_f = 1'b1;
      end else begin
        ns++;
      end
      @(posedge clk);
      #1;
    end
    check_eq("op_released", {31'b0, done_f}, 32'h1);
    bus.valid     = 1'b0;
    bus.muldiv_op = '0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int          ns;
    logic [31:0] r;
    int          exp_ns;
    exp_ns = (op == OP_MULT || op == OP_MULTU) ? 2 :
             (op == OP_DIV  || op == OP_DIVU)  ? 33 : 0;
    model_exec(op, a, b);
    do_op(op, a, b, ns, r);
    check_eq({tag, "_stall"}, 32'(ns), 32'(exp_ns));
  endtask

  task automatic read_hilo(input string tag);
    int          ns;
    logic [31:0] r;
    exp_q.push_back(model_hi);
    do_op(OP_MFHI, 32'h0, 32'h0, ns, r);
    check_eq({tag, "_hi"}, r, exp_q.pop_front());
    exp_q.push_back(model_lo);
    do_op(OP_MFLO, 32'h0, 32'h0, ns, r);
    check_eq({tag, "_lo"}, r, exp_q.pop_front());
  endtask

  initial begin
    logic [7:0]  rops [4];
    logic [7:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

    rst           = 1'b1;
    bus.valid     = 1'b0;
    bus.muldiv_op = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.flush     = 1'b0;
    model_hi      = '0;
    model_lo      = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall", {31'b0, bus.stall}, 32'h0);
    check_eq("rst_result", bus.result, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    read_hilo("reset");

    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    read_hilo("mult");
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_hilo("multu");
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    read_hilo("div_neg");
    run_op("divu_zero", OP_DIVU, 32'd100, 32'd0);
    read_hilo("divu_zero");
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    read_hilo("div_ovf");

    // Flush during the tenth divide cycle must drop stall at once and leave HI/LO alone.
    run_op("mthi", OP_MTHI, 32'h0000_1234, 32'h0);
    run_op("mtlo", OP_MTLO, 32'h0000_5678, 32'h0);
    bus.valid     = 1'b1;
    bus.muldiv_op = OP_DIVU;
    bus.src_a     = 32'd10;
    bus.src_b     = 32'd3;
    @(negedge clk);
    check_eq("flush_c0_stall", {31'b0, bus.stall}, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("flush_c10_pre", {31'b0, bus.stall}, 32'h1);
    bus.flush = 1'b1;
    #1;
    check_eq("flush_stall", {31'b0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.valid     = 1'b0;
    bus.muldiv_op = '0;
    @(negedge clk);
    check_eq("flush_idle_stall", {31'b0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    read_hilo("flush");

    // No result without valid.
    bus.valid     = 1'b0;
    bus.muldiv_op = OP_MFHI;
    #1;
    check_eq("novalid_result", bus.result, 32'h0);
    bus.muldiv_op = '0;

    // Multi-hot op must neither stall, drive result, nor write.
    bus.valid     = 1'b1;
    bus.muldiv_op = 8'h0C;
    bus.src_a     = 32'hDEAD_BEEF;
    #1;
    check_eq("multihot_stall", {31'b0, bus.stall}, 32'h0);
    check_eq("multihot_result", bus.result, 32'h0);
    @(posedge clk);
    #1;
    bus.valid     = 1'b0;
    bus.muldiv_op = '0;
    read_hilo("multihot");

    // Reset pulse while the multiply is in flight.
    bus.valid     = 1'b1;
    bus.muldiv_op = OP_MULT;
    bus.src_a     = 32'h0000_0007;
    bus.src_b     = 32'h0000_0009;
    @(posedge clk);
    #2;
    check_eq("mul_busy_stall", {31'b0, bus.stall}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_stall", {31'b0, bus.stall}, 32'h0);
    check_eq("rst_mid_result", bus.result, 32'h0);
    @(posedge clk);
    #1;
    bus.valid     = 1'b0;
    bus.muldiv_op = '0;
    rst           = 1'b0;
    model_hi      = '0;
    model_lo      = '0;
    @(posedge clk);
    #1;
    read_hilo("rst_mid");

    for (int i = 0; i < 8; i++) begin
      rop = rops[i % 4];
      ra  = $urandom;
      rb  = (i == 7) ? 32'h0 : ((i % 3 == 0) ? $urandom_range(1, 255) : $urandom);
      run_op("rand", rop, ra, rb);
      read_hilo("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
